muldiv_unit: RTL and testbench

// - Iterative multiply/divide unit hanging off the EX stage of the 5-stage pipeline; owns the HI/LO registers.
// - Takes srcAE/srcBE (post-forwarding operands) on startE.
// - Raises busy, which the hazard unit folds into stallF/stallD.
// - Writes HI/LO on completion and pulses done.

---
 rtl/muldiv_unit.sv | 208 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit attached to the EX stage. It owns the HI/LO
// registers, runs one radix-2 step per cycle over operand magnitudes, and
// fixes up signs when the result is written.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-low reset
//   startE  begin operation opE this cycle (suppressed by flushE)
//   flushE  EX flush
//   opE     00 mult, 01 multu, 10 div, 11 divu
//   srcAE   multiplicand / dividend
//   srcBE   multiplier / divisor
//   hiweW   mthi write (only while not busy)
//   loweW   mtlo write (only while not busy)
//   wdataW  mthi/mtlo data
//   abort   cancel an in-flight operation
//   busy    operation in progress
//   done    one-cycle pulse, HI/LO hold the new result
//   hi, lo  HI and LO registers
//
// Optional build macro MULDIV_FAST_MUL_EN: mult/multu complete through a
// combinational multiplier in a single edge and never raise busy. Division
// stays iterative either way.

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic             flushE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic             hiweW,
  input  logic             loweW,
  input  logic [WIDTH-1:0] wdataW,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_next;

  // Working registers. For multiply, {acc, q} is the shifting product with m
  // the multiplicand magnitude. For divide, acc is the partial remainder, q
  // shifts the dividend out and the quotient in, and m is the divisor.
  logic [WIDTH-1:0] acc, q, m, a_raw;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, div_zero;

  logic             start_ok, load, finish, fast_start, last;
  logic             op_signed;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [WIDTH:0]   mul_sum, shifted, diff;
  logic [WIDTH-1:0] acc_step, q_step, quo, rem;
  logic [2*WIDTH-1:0] prod_mag, result;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  assign op_signed = ~opE[0];
  assign mag_a     = magnitude(srcAE, op_signed);
  assign mag_b     = magnitude(srcBE, op_signed);
  assign start_ok  = startE & ~flushE & (state != RUN);
  assign last      = (cnt == CW'(WIDTH - 1));

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_mag, fast_prod;
  assign fast_start = ~opE[1];
  assign fast_mag   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign fast_prod  = (op_signed & (srcAE[WIDTH-1] ^ srcBE[WIDTH-1])) ? -fast_mag : fast_mag;
`else
  assign fast_start = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A start accepted from FIN chains straight into the next operation; a fast
  // multiply goes directly to FIN because its result is written on the start edge.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          load       = 1'b1;
          state_next = fast_start ? FIN : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (div_zero || last) begin
          finish     = 1'b1;
          state_next = FIN;
        end
      end
      FIN: begin
        done = 1'b1;
        if (start_ok) begin
          load       = 1'b1;
          state_next = fast_start ? FIN : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One radix-2 step. The divide trial subtraction borrows into bit WIDTH
  // exactly when the shifted remainder is smaller than the divisor.
  always_comb begin
    mul_sum  = '0;
    shifted  = '0;
    diff     = '0;
    acc_step = acc;
    q_step   = q;
    if (is_div) begin
      shifted = {acc, q[WIDTH-1]};
      diff    = shifted - {1'b0, m};
      if (!diff[WIDTH]) begin
        acc_step = diff[WIDTH-1:0];
        q_step   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = shifted[WIDTH-1:0];
        q_step   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      acc_step = mul_sum[WIDTH:1];
      q_step   = {mul_sum[0], q[WIDTH-1:1]};
    end
  end

  // Final result comes from the last step's outputs so HI/LO land on the same
  // edge that leaves RUN. most-negative / -1 needs no special case: the
  // magnitude quotient is already the most-negative bit pattern.
  always_comb begin
    prod_mag = {acc_step, q_step};
    quo      = neg_q ? -q_step : q_step;
    rem      = neg_r ? -acc_step : acc_step;
    if (div_zero)    result = {a_raw, {WIDTH{1'b1}}};
    else if (is_div) result = {rem, quo};
    else             result = neg_q ? -prod_mag : prod_mag;
  end

  // mthi/mtlo are applied after any result write so they win in FIN and on a
  // fast-multiply start edge; they are blocked only while RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      a_raw    <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (load) begin
        acc      <= '0;
        cnt      <= '0;
        is_div   <= opE[1];
        a_raw    <= srcAE;
        m        <= opE[1] ? mag_b : mag_a;
        q        <= opE[1] ? mag_a : mag_b;
        neg_q    <= op_signed & (srcAE[WIDTH-1] ^ srcBE[WIDTH-1]);
        neg_r    <= op_signed & srcAE[WIDTH-1];
        div_zero <= opE[1] & (srcBE == '0);
      end else if (state == RUN) begin
        acc <= acc_step;
        q   <= q_step;
        cnt <= cnt + 1'b1;
      end
      if (finish) {hi, lo} <= result;
`ifdef MULDIV_FAST_MUL_EN
      if (load && fast_start) {hi, lo} <= fast_prod;
`endif
      if (!busy) begin
        if (hiweW) hi <= wdataW;
        if (loweW) lo <= wdataW;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench for muldiv_unit. Results are predicted with plain
// 64-bit arithmetic on sign- or zero-extended operands; latency and busy
// length are predicted from the operation type. Honours MULDIV_FAST_MUL_EN
// when the design is built with it.

module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startE = 1'b0, flushE = 1'b0, hiweW = 1'b0, loweW = 1'b0, abort = 1'b0;
  logic [1:0]  opE = 2'b00;
  logic [31:0] srcAE = '0, srcBE = '0, wdataW = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checkCount = 0;
  int passCount  = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .startE(startE), .flushE(flushE), .opE(opE),
    .srcAE(srcAE), .srcBE(srcBE), .hiweW(hiweW), .loweW(loweW), .wdataW(wdataW),
    .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  // Reference result {hi, lo} from ordinary arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qv, rv;
    logic [63:0] r;
    if (op[0]) begin
      sa = longint'(a);
      sb = longint'(b);
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    if (!op[1]) begin
      r = sa * sb;
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else begin
      qv = sa / sb;
      rv = sa % sb;
      r  = {rv[31:0], qv[31:0]};
    end
    return r;
  endfunction

  function automatic int expLatency(input logic [1:0] op, input logic [31:0] b);
    int lat;
    lat = (op[1] && b == 32'd0) ? 2 : WIDTH + 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[1]) lat = 1;
`endif
    return lat;
  endfunction

  // Issue one operation, optionally re-pulse startE at cycle N+injectAt, then
  // check latency, busy length, result and the single-cycle done pulse.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int injectAt);
    logic [63:0] exp;
    int cyc, busyCnt, lat;
    exp = refModel(op, a, b);
    lat = expLatency(op, b);
    @(negedge clk);
    startE = 1'b1; opE = op; srcAE = a; srcBE = b;
    @(negedge clk);
    startE = 1'b0; opE = 2'($urandom); srcAE = $urandom; srcBE = $urandom;
    cyc = 1; busyCnt = 0;
    while (!done && cyc <= 100) begin
      if (busy) busyCnt++;
      startE = (cyc == injectAt);
      @(negedge clk);
      cyc++;
    end
    startE = 1'b0;
    checkOutput($sformatf("%s.latency", tag), 64'(cyc), 64'(lat));
    checkOutput($sformatf("%s.busyCycles", tag), 64'(busyCnt), 64'(lat - 1));
    checkOutput($sformatf("%s.busyAtDone", tag), 64'(busy), 64'd0);
    checkOutput($sformatf("%s.hi", tag), 64'(hi), 64'(exp[63:32]));
    checkOutput($sformatf("%s.lo", tag), 64'(lo), 64'(exp[31:0]));
    @(negedge clk);
    checkOutput($sformatf("%s.doneOneCycle", tag), 64'(done), 64'd0);
  endtask

  // Interrupt a divu at cycle N+10 with either reset or abort.
  task automatic interruptTest(input bit useReset);
    logic [63:0] prior;
    bit sawDone;
    string tag;
    tag = useReset ? "intReset" : "intAbort";
    applyStimulus({tag, ".pre"}, 2'b01, 32'h0000_1234, 32'h0000_0010, 0);
    prior = {hi, lo};
    @(negedge clk);
    startE = 1'b1; opE = 2'b11; srcAE = 32'h0000_FFFF; srcBE = 32'h0000_0003;
    @(negedge clk);
    startE = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput({tag, ".busyBefore"}, 64'(busy), 64'd1);
    if (useReset) begin
      reset = 1'b0;
      #1;
      checkOutput({tag, ".hiLoCleared"}, {hi, lo}, 64'd0);
      checkOutput({tag, ".busyCleared"}, 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
    end else begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput({tag, ".busyAfter"}, 64'(busy), 64'd0);
      checkOutput({tag, ".hiLoKept"}, {hi, lo}, prior);
    end
    sawDone = 1'b0;
    repeat (WIDTH + 5) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput({tag, ".noDone"}, 64'(sawDone), 64'd0);
    checkOutput({tag, ".hiLoFinal"}, {hi, lo}, useReset ? 64'd0 : prior);
  endtask

  initial begin
    logic [63:0] prior, exp;
    int cyc;
    logic [1:0]  op;
    logic [31:0] a, b;

    #2 reset = 1'b0;
    #10;
    checkOutput("reset.hi", 64'(hi), 64'd0);
    checkOutput("reset.lo", 64'(lo), 64'd0);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus("multu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0);
    applyStimulus("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    applyStimulus("divu_7d0", 2'b11, 32'h0000_0007, 32'h0000_0000, 0);
    applyStimulus("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5);
    applyStimulus("div_m9d0", 2'b10, 32'hFFFF_FFF7, 32'h0000_0000, 0);

    interruptTest(1'b1);
    interruptTest(1'b0);

    // mthi / mtlo while idle
    @(negedge clk);
    hiweW = 1'b1; wdataW = 32'h1234_5678;
    @(negedge clk);
    hiweW = 1'b0;
    checkOutput("mthi.idle", 64'(hi), 64'h1234_5678);
    hiweW = 1'b1; loweW = 1'b1; wdataW = 32'hA5A5_0F0F;
    @(negedge clk);
    hiweW = 1'b0; loweW = 1'b0;
    checkOutput("mthilo.both", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});

    // mthi while busy is dropped
    prior = {hi, lo};
    exp = refModel(2'b11, 32'd100, 32'd7);
    @(negedge clk);
    startE = 1'b1; opE = 2'b11; srcAE = 32'd100; srcBE = 32'd7;
    @(negedge clk);
    startE = 1'b0;
    repeat (2) @(negedge clk);
    hiweW = 1'b1; wdataW = 32'hDEAD_BEEF;
    @(negedge clk);
    hiweW = 1'b0;
    checkOutput("mthi.busy", {hi, lo}, prior);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("mthi.busyResult", {hi, lo}, exp);

    // flushed start does nothing
    prior = {hi, lo};
    @(negedge clk);
    startE = 1'b1; flushE = 1'b1; opE = 2'b11; srcAE = 32'd7; srcBE = 32'd3;
    @(negedge clk);
    startE = 1'b0; flushE = 1'b0;
    checkOutput("flush.busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("flush.done", 64'(done), 64'd0);
    checkOutput("flush.hiLo", {hi, lo}, prior);

    // randomized operations, with corner operands mixed in
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      applyStimulus($sformatf("rand%0d", i), op, a, b, 0);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
